ysyx_22050039_ifu: RTL and testbench

Instruction fetch unit for the single-issue RV64 core; it supplies the 32-bit instruction word that the decode unit consumes. It owns the PC register and issues one outstanding request at a time to instruction memory. It buffers the returned word and presents it to decode with a valid/ready handshake. It accepts PC redirects (pc_wen/pc_wdata) from decode/execute and discards any stale in-flight fetch.

---
 rtl/ysyx_22050039_ifu.sv | 76 +++++++
 tb/tb_ysyx_22050039_ifu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_ifu.sv
// ysyx_22050039_ifu: RV64 instruction fetch unit, one outstanding imem request, buffered word to decode
// ports: clk/rst (async, active-low); imem_req_valid/imem_req_ready/imem_addr request channel;
//        imem_resp_valid/imem_resp_data response; inst_valid/inst_ready/inst/inst_pc to decode;
//        pc_wen/pc_wdata redirect from decode/execute
module ysyx_22050039_ifu #(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  input  logic                pc_wen,
  input  logic [XLEN-1:0]     pc_wdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, redir_pc;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic drop_q, drop_d;
  assign redir_pc = {pc_wdata[XLEN-1:2], 2'b00};
  assign imem_req_valid = state_q == REQ;
  assign inst_valid = state_q == HOLD;
  assign imem_addr = pc_q;
  assign inst = inst_q;
  assign inst_pc = inst_pc_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_wen ? redir_pc : pc_q;
    drop_d = drop_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_req_ready) begin
        state_d = WAIT;
        // the old address already went out, so its word must be thrown away
        drop_d = pc_wen;
      end
      WAIT: if (imem_resp_valid) begin
        state_d = (drop_q || pc_wen) ? REQ : HOLD;
        drop_d = 1'b0;
        if (!drop_q && !pc_wen) begin
          inst_d = imem_resp_data;
          inst_pc_d = pc_q;
          pc_d = pc_q + XLEN'(4);
        end
      end else if (pc_wen) drop_d = 1'b1;
      HOLD: if (inst_ready || pc_wen) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      inst_q <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// tb_ysyx_22050039_ifu: randomized scoreboard bench for the fetch unit
module tb_ysyx_22050039_ifu;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] W_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0, inst_valid, inst_ready = 0, pc_wen = 0;
  logic [63:0] imem_addr, inst_pc, pc_wdata = 0;
  logic [31:0] imem_resp_data = 0, inst;
  logic w_req_valid, w_inst_valid;
  logic [63:0] w_addr, w_inst_pc;
  logic [31:0] w_inst;
  int checks = 0, errors = 0, delivered = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;

  ysyx_22050039_ifu dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata)
  );

  ysyx_22050039_ifu #(.RESET_PC(W_PC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_addr(w_addr), .imem_resp_valid(1'b1), .imem_resp_data(32'h0000_0413),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst(w_inst), .inst_pc(w_inst_pc),
    .pc_wen(1'b0), .pc_wdata(64'h0)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // monitor: inputs visible at a negedge are the ones the DUT saw at the previous posedge
  initial begin
    logic prev_iv;
    logic [31:0] hold_inst;
    logic [63:0] hold_pc, e;
    int idle_cyc;
    prev_iv = 0;
    idle_cyc = 0;
    hold_inst = 0;
    hold_pc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_addr", imem_addr, RST_PC);
        prev_iv = 0;
        idle_cyc = 0;
      end else begin
        if (inst_valid && imem_req_valid) chk("req_and_inst_valid", 1, 0);
        if (prev_iv) begin
          chk("hold_inst_valid", inst_valid, !(inst_ready || pc_wen));
          if (inst_ready || pc_wen) chk("hold_exit_req", imem_req_valid, 1);
          if (inst_valid) begin
            chk("hold_inst_stable", inst, hold_inst);
            chk("hold_pc_stable", inst_pc, hold_pc);
          end
        end else if (inst_valid) begin
          chk("latency_resp_prev", imem_resp_valid, 1);
          if (exp_q.size() == 0) chk("exp_avail", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e);
            chk("inst", inst, mem_word(e));
            exp_q.push_back(e + 64'd4);
          end
          delivered++;
          idle_cyc = 0;
          hold_inst = inst;
          hold_pc = inst_pc;
        end
        if (++idle_cyc > 300) begin
          chk("progress_timeout", 0, 1);
          idle_cyc = 0;
        end
        prev_iv = inst_valid;
      end
    end
  end

  // second instance: fetch from the top of the address space must wrap to 0
  initial begin
    logic found;
    repeat (4) @(negedge clk);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = w_inst_valid;
    end
    chk("wrap_inst_seen", found, 1);
    chk("wrap_inst_pc", w_inst_pc, W_PC);
    chk("wrap_inst", w_inst, 32'h0000_0413);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = w_req_valid;
    end
    chk("wrap_req_seen", found, 1);
    chk("wrap_next_addr", w_addr, 64'h0);
  end

  // driver + memory model
  initial begin
    logic pend;
    logic [63:0] pend_addr;
    int pend_dly, ph;
    pend = 0;
    pend_addr = 0;
    pend_dly = 0;
    #1 rst = 0;
    exp_q.push_back(RST_PC);
    repeat (3) @(negedge clk);
    #1 rst = 1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      #1;
      ph = (cyc / 700) % 3;
      rst = !((cyc % 1500) inside {[1490:1492]});
      if (!rst) begin
        exp_q.delete();
        exp_q.push_back(RST_PC);
        if (pend && cyc % 1500 == 1490) pend_dly = 5;
      end
      imem_resp_valid = 0;
      imem_resp_data = $urandom;
      if (pend) begin
        if (pend_dly == 0) begin
          imem_resp_valid = 1;
          imem_resp_data = mem_word(pend_addr);
          pend = 0;
        end else pend_dly--;
      end else if (!imem_req_valid && $urandom_range(0, 7) == 0) imem_resp_valid = 1;
      inst_ready = ph == 1 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 3) != 0;
      pc_wen = rst && (ph == 2 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 23) == 0);
      case ($urandom_range(0, 3))
        0: pc_wdata = RST_PC + 64'($urandom_range(0, 255));
        1: pc_wdata = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        2: pc_wdata = {$urandom, $urandom};
        default: pc_wdata = 64'h0000_0000_8000_1002;
      endcase
      imem_req_ready = !pend && (ph == 0 || $urandom_range(0, 1) == 1);
      if (rst && imem_req_valid && imem_req_ready) begin
        pend = 1;
        pend_addr = imem_addr;
        pend_dly = $urandom_range(0, 3);
      end
      if (pc_wen) begin
        exp_q.delete();
        exp_q.push_back(pc_wdata & ~64'h3);
      end
    end
    chk("delivered_enough", delivered > 100, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
